// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: shared constants and types for the UART MMIO front end.
//   - register offsets within the 256 B window
//   - status register bit positions and the packed status layout
//   - satLevel(): clamps a FIFO occupancy to the 8-bit level fields
package uart_mmio_pkg;

    localparam logic [7:0] UART_STATUS_OFS = 8'h00;
    localparam logic [7:0] UART_RX_OFS     = 8'h04;
    localparam logic [7:0] UART_TX_OFS     = 8'h08;
    localparam logic [7:0] UART_IRQEN_OFS  = 8'h0C;
    localparam logic [7:0] UART_CYC_OFS    = 8'h10;
    localparam logic [7:0] UART_CYCRST_OFS = 8'h18;

    localparam int STS_TX_NOT_FULL  = 0;
    localparam int STS_RX_NOT_EMPTY = 1;
    localparam int STS_RX_OVERFLOW  = 2;
    localparam int STS_TX_DROP      = 3;
    localparam int STS_RX_LEVEL_LSB = 8;
    localparam int STS_TX_LEVEL_LSB = 16;

    // Field order matches the bit positions above (MSB first).
    typedef struct packed {
        logic [7:0] rsvdHi;
        logic [7:0] txLevel;
        logic [7:0] rxLevel;
        logic [3:0] rsvdLo;
        logic       txDrop;
        logic       rxOverflow;
        logic       rxNotEmpty;
        logic       txNotFull;
    } uart_status_t;

    // Occupancy of a 256-deep FIFO needs 9 bits; the register field has 8.
    function automatic logic [7:0] satLevel(input logic [8:0] lvl);
        return lvl[8] ? 8'hFF : lvl[7:0];
    endfunction

endpackage

// File: rtl/uart_mmio_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head read.
//   clk, rst   : clock, synchronous active-high reset (pointers/count only)
//   push, din  : write request; accepted when not full, or when full and a
//                pop is accepted on the same edge (caller gates push if that
//                rescue is not wanted)
//   pop, dout  : read request (ignored when empty); dout is the current head
//   full, empty: occupancy flags
//   level      : exact occupancy, DEPTH_LOG2+1 bits
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int DEPTH_LOG2 = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
    logic [DEPTH_LOG2:0]   count;
    logic                  doPush, doPop;

    assign empty  = (count == '0);
    assign full   = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign level  = count;
    assign dout   = mem[rdPtr];
    assign doPop  = pop & ~empty;
    // When full, the slot being written is the one being read out this edge.
    assign doPush = push & (~full | doPop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= din;
    end

endmodule

// File: rtl/uart_mmio_fifo.sv
// uart_mmio_fifo: memory-mapped UART front end with TX/RX FIFOs.
//   CPU side : addr/wdata/rd_en/wr_en issued in E stage; hit is combinational,
//              rdata is registered (valid the cycle after rd_en).
//   UART side: uart_tx_* drains the TX FIFO (ready/valid), uart_rx_* fills
//              the RX FIFO (no back-pressure; overflow is flagged).
//   Optional : define UART_MMIO_IRQ_EN to add the irq output and the
//              interrupt-enable register at offset 0x0C.
module uart_mmio_fifo
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          TX_DEPTH  = 8,
    parameter int          RX_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        rd_en,
    input  logic        wr_en,
    output logic        hit,
    output logic [31:0] rdata,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
`ifdef UART_MMIO_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int TXL = $clog2(TX_DEPTH) + 1;
    localparam int RXL = $clog2(RX_DEPTH) + 1;

    logic [7:0]     ofs;
    logic           rdHit, wrHit;
    logic           stsRd, rxRd, txWr, cycRst;
    logic           txFull, txEmpty, txPush, txPop;
    logic           rxFull, rxEmpty;
    logic [7:0]     txHead, rxHead;
    logic [TXL-1:0] txLevel;
    logic [RXL-1:0] rxLevel;
    logic           rxOverflow, txDrop, rxOvfSet, txDropSet;
    logic [31:0]    cycleCnt;
    logic           rxReady;
    uart_status_t   sts;
    logic [31:0]    rdNext;

    assign hit    = (addr[31:8] == BASE_ADDR[31:8]);
    assign ofs    = addr[7:0];
    assign rdHit  = rd_en & hit;
    assign wrHit  = wr_en & hit;
    assign stsRd  = rdHit & (ofs == UART_STATUS_OFS);
    assign rxRd   = rdHit & (ofs == UART_RX_OFS);
    assign txWr   = wrHit & (ofs == UART_TX_OFS);
    assign cycRst = wrHit & (ofs == UART_CYCRST_OFS);

    // TX: fullness is judged before the edge, so a concurrent drain does not
    // make room for the store.
    assign txPush    = txWr & ~txFull;
    assign txPop     = uart_tx_ready;
    assign txDropSet = txWr & txFull;

    // RX: a CPU pop on the same edge does make room for the incoming byte.
    assign rxOvfSet  = uart_rx_valid & rxFull & ~rxRd;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) txFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (txPush),
        .pop   (txPop),
        .din   (wdata[7:0]),
        .dout  (txHead),
        .full  (txFull),
        .empty (txEmpty),
        .level (txLevel)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) rxFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (uart_rx_valid),
        .pop   (rxRd),
        .din   (uart_rx_data),
        .dout  (rxHead),
        .full  (rxFull),
        .empty (rxEmpty),
        .level (rxLevel)
    );

    assign uart_tx_data  = txHead;
    assign uart_tx_valid = ~txEmpty;
    assign uart_rx_ready = rxReady;

    always_comb begin
        sts            = '0;
        sts.txNotFull  = ~txFull;
        sts.rxNotEmpty = ~rxEmpty;
        sts.rxOverflow = rxOverflow;
        sts.txDrop     = txDrop;
        sts.rxLevel    = satLevel(9'(rxLevel));
        sts.txLevel    = satLevel(9'(txLevel));
    end

`ifdef UART_MMIO_IRQ_EN
    logic rxIrqEn, txIrqEn;
`endif

    always_comb begin
        rdNext = '0;
        case (ofs)
            UART_STATUS_OFS: rdNext = sts;
            UART_RX_OFS:     rdNext = {24'b0, rxEmpty ? 8'h00 : rxHead};
            UART_CYC_OFS:    rdNext = cycleCnt;
`ifdef UART_MMIO_IRQ_EN
            UART_IRQEN_OFS:  rdNext = {30'b0, txIrqEn, rxIrqEn};
`endif
            default:         rdNext = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata      <= '0;
            rxOverflow <= 1'b0;
            txDrop     <= 1'b0;
            cycleCnt   <= '0;
            rxReady    <= 1'b0;
        end else begin
            rxReady <= 1'b1;
            if (rdHit) rdata <= rdNext;
            // Reading status clears the sticky bits, but a new event on the
            // same edge keeps them set.
            if (rxOvfSet)   rxOverflow <= 1'b1;
            else if (stsRd) rxOverflow <= 1'b0;
            if (txDropSet)  txDrop <= 1'b1;
            else if (stsRd) txDrop <= 1'b0;
            cycleCnt <= cycRst ? 32'h0 : cycleCnt + 32'h1;
        end
    end

`ifdef UART_MMIO_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rxIrqEn <= 1'b0;
            txIrqEn <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (wrHit && ofs == UART_IRQEN_OFS) begin
                rxIrqEn <= wdata[0];
                txIrqEn <= wdata[1];
            end
            irq <= (rxIrqEn & ~rxEmpty) | (txIrqEn & txEmpty) | rxOverflow;
        end
    end
`endif

endmodule

// File: doc/uart_mmio_fifo.md
Name: uart_mmio_fifo

Overview:
- Parametrised memory-mapped UART front end. Replaces the single-byte UART control/encode glue in the 3-stage datapath.
- Buffers transmit and receive bytes in FIFOs of configurable depth. Adds sticky error flags, FIFO level reporting and a free-running cycle counter.
- CPU side: access issued in the E stage, read data returned registered for the M stage. UART side: byte-wide ready/valid to the serializer core.

Parameters:
- BASE_ADDR, 32'h8000_0000, MMIO window base; window is BASE_ADDR[31:8] match, 256 B.
- TX_DEPTH, 8, TX FIFO entries; power of 2, 2..256.
- RX_DEPTH, 8, RX FIFO entries; power of 2, 2..256.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- addr  in  32  E-stage byte address (word aligned).
- wdata  in  32  store data; byte in [7:0].
- rd_en  in  1  load issued this cycle.
- wr_en  in  1  store issued this cycle.
- hit  out  1  combinational: addr falls in window.
- rdata  out  32  registered read data, valid the cycle after rd_en.
- uart_tx_data  out  8  TX FIFO head.
- uart_tx_valid  out  1  TX FIFO non-empty.
- uart_tx_ready  in  1  serializer accepts byte.
- uart_rx_data  in  8  received byte.
- uart_rx_valid  in  1  received byte strobe.
- uart_rx_ready  out  1  constant 1 after reset; no back-pressure, overflow is flagged instead.

Behaviour:
- Reset (rst=1 at posedge clk): both FIFOs empty, pointers 0, flags 0, cycle_cnt 0, rdata 0, uart_tx_valid 0, uart_rx_ready 0. From the first cycle after reset, uart_rx_ready is 1.
- Register map (offset from BASE_ADDR):
  - 0x00 status, read-only:
    - [0] tx_not_full
    - [1] rx_not_empty
    - [2] rx_overflow, sticky
    - [3] tx_drop, sticky
    - [15:8] rx_level
    - [23:16] tx_level
    - other bits 0
  - 0x04 rx data, read pops RX: rdata = {24'b0, byte}.
  - 0x08 tx data, write pushes wdata[7:0].
  - 0x10 cycle_cnt, read-only.
  - 0x18 counter reset: any write clears cycle_cnt to 0 the next cycle.
  - Other offsets read 0. Writes to them are ignored.
- Reads:
  - rdata is latched at posedge where rd_en&hit. It holds its value otherwise.
  - Latency: exactly 1 cycle.
  - Out-of-window reads leave rdata unchanged (the datapath muxes on its own registered hit).
- RX pop:
  - Occurs on the same edge as the read. RX empty: rdata=0, no pop, no flag.
- TX push:
  - Accepted iff TX not full before the edge.
  - TX full: byte dropped, tx_drop set.
  - A pop on the same edge does not rescue a push into a full FIFO.
- TX drain:
  - uart_tx_valid = !tx_empty. Pop on uart_tx_valid & uart_tx_ready.
  - Push and pop on the same edge are both honoured; level is unchanged.
- RX fill:
  - Push on uart_rx_valid when RX not full.
  - RX full: byte discarded, rx_overflow set.
  - CPU pop and UART push on the same edge are both honoured.
  - No empty bypass: a byte pushed at edge N is readable by a load issued at cycle N+1 or later.
- Sticky flags:
  - Cleared on the edge where status is read; rdata carries the pre-clear value.
  - Set and clear on the same edge: set wins.
- cycle_cnt:
  - Increments every cycle, 32-bit, wraps 0xFFFF_FFFF -> 0.
  - Clear via 0x18 has priority over increment.
- rd_en and wr_en together: both are processed independently.
- Level fields saturate at 255. Counts are exact for DEPTH ≤ 255; DEPTH 256 reports 255 when full.
- rst asserted mid-operation:
  - All contents are lost and any in-flight read result is discarded; rdata reads 0.
  - uart_tx_valid drops the cycle after the reset edge, even mid-handshake.

Optional Feature:
- Macro UART_MMIO_IRQ_EN.
- Defined:
  - Adds output irq (1 bit, registered, reset 0).
  - Adds RW register 0x0C: [0] rx_irq_en, [1] tx_irq_en, reset 0.
  - irq <= (rx_irq_en & rx_not_empty) | (tx_irq_en & tx_empty) | rx_overflow.
- Undefined: no irq port; 0x0C reads 0 and ignores writes.

Decomposition:
- Shared package uart_mmio_pkg:
  - offset constants UART_STATUS_OFS, UART_RX_OFS, UART_TX_OFS, UART_IRQEN_OFS, UART_CYC_OFS, UART_CYCRST_OFS
  - status bit-index constants
  - typedef uart_status_t (packed struct)
- One sub-module, sync_fifo:
  - parameters WIDTH, DEPTH
  - ports push, pop, din, dout, full, empty, level
  - (DEPTH_LOG2+1)-bit count, head read combinational
  - instantiated twice.

Test Plan:
- Reset, then read 0x00 -> rdata 32'h0000_0001 one cycle after rd_en; uart_rx_ready 1; uart_tx_valid 0.
- With uart_tx_ready=0, write 0x41..0x48 to 0x08, then a 9th write 0x49 -> status 32'h0008_0008, i.e. tx_level 8, tx_drop set. Raise uart_tx_ready -> bytes 0x41..0x48 emerge in order, 0x49 never appears. Second status read -> tx_drop 0.
- Inject 9 RX bytes 0x10..0x18 (RX_DEPTH 8) -> status shows rx_level 8, rx_overflow 1. Eight reads of 0x04 return 0x10..0x17; a ninth returns 0.
- Same cycle: uart_rx_valid with byte 0x55 and a CPU pop of 0x04 when rx_level=8 -> level stays 8, no overflow, popped byte returned.
- Read 0x10 twice 5 cycles apart -> difference 5. Write 0x18 -> read two cycles later returns 1. Force cycle_cnt 0xFFFF_FFFF -> next value 0.
- UART_MMIO_IRQ_EN build: write 0x0C=1, push one RX byte -> irq 1 two edges after uart_rx_valid. Pop it -> irq 0 one edge after RX empties.
